// File: rtl/spi_slave_shifter_if.sv
// Pin-side and register-file-side signals of the SPI slave shifter.
// The slave modport is the shifter's view; the master modport is the view of the logic that drives it.
`timescale 1ns/1ps
interface spi_slave_shifter_if #(parameter int DATA_WIDTH = 8);
  logic                  cpol;
  logic                  cpha;
  logic                  lsbfe;
  logic                  ss;
  logic                  sclk_in;
  logic                  mosi;
  logic                  miso;
  logic                  miso_oe;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_load;
  logic                  tx_ready;
  logic                  tx_underrun;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  busy;

  modport slave (
    input  cpol, cpha, lsbfe, ss, sclk_in, mosi, tx_data, tx_load,
    output miso, miso_oe, tx_ready, tx_underrun, rx_data, rx_valid, busy
  );

  modport master (
    output cpol, cpha, lsbfe, ss, sclk_in, mosi, tx_data, tx_load,
    input  miso, miso_oe, tx_ready, tx_underrun, rx_data, rx_valid, busy
  );
endinterface

// File: rtl/spi_slave_shifter.sv
// SPI slave datapath: synchronises sclk/ss/mosi into PCLK, shifts mosi into rx words and
// drives miso from a single-entry tx buffer.
//
//   state  | meaning
//   IDLE   | synced ss high; no edges processed, outputs released
//   ACTIVE | synced ss low; sample/shift edges move data, words run back to back
`timescale 1ns/1ps
module spi_slave_shifter #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic           PCLK,
  input logic           PRESETn,
  spi_slave_shifter_if.slave spi
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [0:0] {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_s;
  logic                   ss_s;
  logic                   mosi_s;

  state_t                 state;
  logic                   sclk_d;
  logic [CW-1:0]          bit_cnt;
  logic [DATA_WIDTH-1:0]  rx_sr;
  logic [DATA_WIDTH-1:0]  tx_sr;
  logic [DATA_WIDTH-1:0]  tx_buf;
  logic                   tx_ready_r;
  logic                   tx_underrun_r;
  logic [DATA_WIDTH-1:0]  rx_data_r;
  logic                   rx_valid_r;
  logic                   word_done;

  logic                   lead_edge;
  logic                   trail_edge;
  logic                   sample_edge;
  logic                   shift_edge;
  logic                   reload;
  logic                   skip_shift;

  // ss resets to deasserted so a reset never looks like a select
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk_in};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0],   spi.ss};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi};
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  always_comb begin
    lead_edge   = (state == ACTIVE) && !ss_s && (sclk_d == spi.cpol) && (sclk_s != spi.cpol);
    trail_edge  = (state == ACTIVE) && !ss_s && (sclk_d != spi.cpol) && (sclk_s == spi.cpol);
    sample_edge = spi.cpha ? trail_edge : lead_edge;
    shift_edge  = spi.cpha ? lead_edge  : trail_edge;
    // cpha=1 holds the first bit: the leading edge of a fresh word is not a shift
    skip_shift  = spi.cpha && (bit_cnt == '0);
    reload      = ((state == IDLE) && !ss_s) ||
                  (shift_edge  && !spi.cpha && (bit_cnt == '0)) ||
                  (sample_edge &&  spi.cpha && (bit_cnt == LAST_BIT));
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state         <= IDLE;
      sclk_d        <= 1'b0;
      bit_cnt       <= '0;
      rx_sr         <= '0;
      tx_sr         <= '0;
      tx_buf        <= '0;
      tx_ready_r    <= 1'b1;
      tx_underrun_r <= 1'b0;
      rx_data_r     <= '0;
      rx_valid_r    <= 1'b0;
      word_done     <= 1'b0;
    end else begin
      tx_underrun_r <= 1'b0;
      rx_valid_r    <= word_done;
      word_done     <= 1'b0;
      sclk_d        <= ss_s ? spi.cpol : sclk_s;

      if (word_done)
        rx_data_r <= rx_sr;

      // a reload consumes the old buffer contents before any same-cycle write lands
      if (reload && !tx_ready_r)
        tx_ready_r <= 1'b1;
      else if (spi.tx_load && tx_ready_r) begin
        tx_buf     <= spi.tx_data;
        tx_ready_r <= 1'b0;
      end

      if (reload) begin
        tx_sr         <= tx_ready_r ? '1 : tx_buf;
        tx_underrun_r <= tx_ready_r;
      end else if (shift_edge && !skip_shift) begin
        if (spi.lsbfe)
          tx_sr <= {1'b0, tx_sr[DATA_WIDTH-1:1]};
        else
          tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
      end

      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (!ss_s)
            state <= ACTIVE;
        end
        ACTIVE: begin
          if (ss_s) begin
            state   <= IDLE;
            bit_cnt <= '0;
          end else if (sample_edge) begin
            if (spi.lsbfe)
              rx_sr <= {mosi_s, rx_sr[DATA_WIDTH-1:1]};
            else
              rx_sr <= {rx_sr[DATA_WIDTH-2:0], mosi_s};
            if (bit_cnt == LAST_BIT) begin
              bit_cnt   <= '0;
              word_done <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign spi.miso        = spi.lsbfe ? tx_sr[0] : tx_sr[DATA_WIDTH-1];
  assign spi.miso_oe     = (state == ACTIVE);
  assign spi.busy        = (state == ACTIVE);
  assign spi.tx_ready    = tx_ready_r;
  assign spi.tx_underrun = tx_underrun_r;
  assign spi.rx_data     = rx_data_r;
  assign spi.rx_valid    = rx_valid_r;

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Bench for spi_slave_shifter: a bit-level SPI master drives the pins and a word-level
// model of the tx buffer predicts miso words, underrun pulses and tx_ready.
`timescale 1ns/1ps
module tb_spi_slave_shifter;
  localparam int W = 8;
  localparam int H = 6;

  logic PCLK = 1'b0;
  logic PRESETn;
  always #5 PCLK = ~PCLK;

  spi_slave_shifter_if #(.DATA_WIDTH(W)) bus();

  spi_slave_shifter #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .spi     (bus)
  );

  int compares = 0;
  int fails    = 0;
  int rx_cnt   = 0;
  int und_cnt  = 0;
  logic [W-1:0] rx_last = '0;

  // word-level model of the tx buffer
  bit           m_full  = 1'b0;
  logic [W-1:0] m_buf   = '0;
  logic [W-1:0] m_cur   = '0;
  int           m_under = 0;

  always @(negedge PCLK) begin
    if (bus.rx_valid) begin
      rx_cnt  <= rx_cnt + 1;
      rx_last <= bus.rx_data;
    end
    if (bus.tx_underrun)
      und_cnt <= und_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic model_reload();
    if (m_full) begin
      m_cur  = m_buf;
      m_full = 1'b0;
    end else begin
      m_cur = '1;
      m_under++;
    end
  endtask

  task automatic load(input logic [W-1:0] w);
    @(negedge PCLK);
    bus.tx_data = w;
    bus.tx_load = 1'b1;
    @(negedge PCLK);
    bus.tx_load = 1'b0;
    if (!m_full) begin
      m_buf  = w;
      m_full = 1'b1;
    end
  endtask

  task automatic set_mode(input logic cp, input logic ch, input logic lf);
    @(negedge PCLK);
    bus.cpol    = cp;
    bus.cpha    = ch;
    bus.lsbfe   = lf;
    bus.sclk_in = cp;
    cyc(8);
  endtask

  task automatic ss_low();
    @(negedge PCLK);
    bus.ss = 1'b0;
    cyc(8);
    model_reload();
  endtask

  task automatic ss_high();
    @(negedge PCLK);
    bus.ss = 1'b1;
    cyc(8);
  endtask

  // master sends nbits of mo and assembles what it samples on miso in the same bit order
  task automatic xfer(input logic [W-1:0] mo, input int nbits, output logic [W-1:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      int pos;
      pos = bus.lsbfe ? i : W - 1 - i;
      if (!bus.cpha) begin
        bus.mosi = mo[pos];
        cyc(H);
        mi[pos] = bus.miso;
        bus.sclk_in = ~bus.cpol;
        cyc(H);
        bus.sclk_in = bus.cpol;
      end else begin
        bus.sclk_in = ~bus.cpol;
        bus.mosi = mo[pos];
        cyc(H);
        mi[pos] = bus.miso;
        bus.sclk_in = bus.cpol;
        cyc(H);
      end
    end
    cyc(H);
  endtask

  task automatic word(input string tag, input logic [W-1:0] mo);
    logic [W-1:0] mi;
    logic [W-1:0] exp_miso;
    int rx0;
    rx0 = rx_cnt;
    exp_miso = m_cur;
    xfer(mo, W, mi);
    model_reload();
    check({tag, "_miso"}, 32'(mi), 32'(exp_miso));
    check({tag, "_rx_pulses"}, 32'(rx_cnt - rx0), 32'd1);
    check({tag, "_rx_data"}, 32'(rx_last), 32'(mo));
    check({tag, "_underruns"}, 32'(und_cnt), 32'(m_under));
    check({tag, "_tx_ready"}, 32'(bus.tx_ready), 32'(!m_full));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"},        32'(bus.miso),        32'd0);
    check({tag, "_miso_oe"},     32'(bus.miso_oe),     32'd0);
    check({tag, "_tx_ready"},    32'(bus.tx_ready),    32'd1);
    check({tag, "_tx_underrun"}, 32'(bus.tx_underrun), 32'd0);
    check({tag, "_rx_data"},     32'(bus.rx_data),     32'd0);
    check({tag, "_rx_valid"},    32'(bus.rx_valid),    32'd0);
    check({tag, "_busy"},        32'(bus.busy),        32'd0);
  endtask

  initial begin
    logic [W-1:0] mi;
    int rx0;
    int nw;

    PRESETn     = 1'b0;
    bus.ss      = 1'b1;
    bus.sclk_in = 1'b0;
    bus.mosi    = 1'b0;
    bus.cpol    = 1'b0;
    bus.cpha    = 1'b0;
    bus.lsbfe   = 1'b0;
    bus.tx_load = 1'b0;
    bus.tx_data = '0;
    cyc(3);
    check_reset_outputs("reset");
    PRESETn = 1'b1;
    cyc(4);

    // mode 0, MSB first, 0xA5 out / 0x3C in
    set_mode(1'b0, 1'b0, 1'b0);
    load(8'hA5);
    check("t1_tx_ready_full", 32'(bus.tx_ready), 32'd0);
    ss_low();
    check("t1_busy", 32'(bus.busy), 32'd1);
    check("t1_miso_oe", 32'(bus.miso_oe), 32'd1);
    check("t1_tx_ready_entry", 32'(bus.tx_ready), 32'(!m_full));
    word("t1", 8'h3C);
    ss_high();
    check("t1_busy_end", 32'(bus.busy), 32'd0);

    // all four modes, LSB first
    for (int m = 0; m < 4; m++) begin
      set_mode(m[1], m[0], 1'b1);
      load(8'h81);
      ss_low();
      word("t2", 8'h6E);
      ss_high();
    end

    // two back-to-back words; second write is ignored while the buffer is full
    set_mode(1'b0, 1'b0, 1'b0);
    load(8'h11);
    load(8'h33);
    ss_low();
    check("t3_tx_ready_entry", 32'(bus.tx_ready), 32'(!m_full));
    load(8'h22);
    word("t3a", 8'h5A);
    word("t3b", 8'hC3);
    ss_high();

    // underrun: nothing loaded before select
    ss_low();
    check("t4_underrun_entry", 32'(und_cnt), 32'(m_under));
    word("t4", 8'($urandom));
    ss_high();

    // select dropped after 5 bits, then a clean word
    load(8'($urandom));
    ss_low();
    rx0 = rx_cnt;
    xfer(8'($urandom), 5, mi);
    ss_high();
    check("t5_no_rx_valid", 32'(rx_cnt - rx0), 32'd0);
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_miso_oe", 32'(bus.miso_oe), 32'd0);
    load(8'($urandom));
    ss_low();
    word("t5", 8'($urandom));
    ss_high();

    // reset in the middle of a word
    set_mode(1'b1, 1'b1, 1'b0);
    load(8'($urandom));
    ss_low();
    xfer(8'($urandom), 3, mi);
    @(negedge PCLK);
    PRESETn = 1'b0;
    #1;
    check_reset_outputs("t6_midword");
    bus.ss = 1'b1;
    bus.sclk_in = bus.cpol;
    m_full = 1'b0;
    cyc(3);
    PRESETn = 1'b1;
    cyc(4);
    load(8'($urandom));
    ss_low();
    word("t6", 8'($urandom));
    ss_high();

    // randomised modes and bursts
    for (int k = 0; k < 6; k++) begin
      set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      load(8'($urandom));
      ss_low();
      nw = $urandom_range(1, 3);
      for (int j = 0; j < nw; j++) begin
        if (j > 0 && $urandom_range(0, 3) != 0)
          load(8'($urandom));
        word("rnd", 8'($urandom));
      end
      ss_high();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
